phase_sequencer: RTL and testbench

Generates the one-hot phase vector `cstate` (IF/DE/EX/WB) that drives the combinational controller. It replaces a free-running phase rotator with one that stalls on memory wait states and supports run, halt, single-step and PC-breakpoint control. It also counts retired instructions and aborts on a memory timeout. It sits between the top level/debug interface and the controller. Datapath load enables (pc_ld, ir_ld, a_ld, b_ld, c_ld, rd_ld, mem_write) are ANDed with `commit` at top level.

---
 rtl/phase_sequencer_pkg.sv | 33 +++
 rtl/phase_sequencer.sv | 169 ++++++++++++++++
 tb/tb_phase_sequencer.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/phase_sequencer_pkg.sv
// Shared definitions for the phase sequencer and the controller it drives.
// Holds the one-hot phase encodings seen on cstate, the sequencer state
// enumeration, and a helper mapping a state to its phase vector.
package phase_sequencer_pkg;

    localparam logic [3:0] PH_HALT = 4'b0000;
    localparam logic [3:0] PH_IF   = 4'b0001;
    localparam logic [3:0] PH_DE   = 4'b0010;
    localparam logic [3:0] PH_EX   = 4'b0100;
    localparam logic [3:0] PH_WB   = 4'b1000;

    typedef enum logic [2:0] {
        ST_HALT = 3'd0,
        ST_IF   = 3'd1,
        ST_DE   = 3'd2,
        ST_EX   = 3'd3,
        ST_WB   = 3'd4
    } state_t;

    // One-hot phase vector for a given state; HALT drives all zeros.
    function automatic logic [3:0] phase_of(input state_t st);
        logic [3:0] ph;
        case (st)
            ST_IF:   ph = PH_IF;
            ST_DE:   ph = PH_DE;
            ST_EX:   ph = PH_EX;
            ST_WB:   ph = PH_WB;
            default: ph = PH_HALT;
        endcase
        return ph;
    endfunction

endpackage

// File: rtl/phase_sequencer.sv
// Instruction phase sequencer.
// Steps HALT -> IF -> DE -> EX -> WB, holding a phase while memory inserts
// wait states, and provides run / halt / single-step / PC-breakpoint control,
// a retired-instruction counter and a memory-timeout abort.
//
// Ports:
//   clock, reset      rising-edge clock, asynchronous active-low reset
//   run               level: keep executing instructions
//   step              pulse: execute one instruction from HALT
//   halt_req          pulse: halt at the next instruction boundary
//   bp_en, bp_addr    PC breakpoint enable and address
//   pc                current program counter
//   mem_req/mem_ready memory access in this phase / access completes now
//   cstate            registered one-hot phase (0000 in HALT)
//   commit            this phase completes now; gates every datapath load
//   running           registered, 1 when not halted
//   bp_hit            sticky, halted by breakpoint; cleared on resume
//   mem_timeout       sticky, halted by memory timeout; cleared on resume
//   instret           retired-instruction counter, wraps
module phase_sequencer
    import phase_sequencer_pkg::*;
#(
    parameter int MAX_WAIT = 255,
    parameter int CNT_W    = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             run,
    input  logic             step,
    input  logic             halt_req,
    input  logic             bp_en,
    input  logic [31:0]      bp_addr,
    input  logic [31:0]      pc,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic [3:0]       cstate,
    output logic             commit,
    output logic             running,
    output logic             bp_hit,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] instret
);

    localparam int WAIT_W     = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
    localparam bit TIMEOUT_EN = (MAX_WAIT != 0);

    state_t              state_r, state_s, adv_s;
    logic [WAIT_W-1:0]   wait_cnt_r, wait_cnt_s;
    logic                halt_pending_r, halt_pending_s;
    logic                step_mode_r, step_mode_s;
    logic                bp_skip_r, bp_skip_s;
    logic                bp_hit_r, bp_hit_s;
    logic                mem_timeout_r, mem_timeout_s;
    logic [CNT_W-1:0]    instret_r, instret_s;
    logic [3:0]          cstate_r;
    logic                running_r;

    logic stall_s, bp_trig_s, timeout_trig_s, commit_s, wb_halt_s;

    assign stall_s        = mem_req & ~mem_ready;
    assign bp_trig_s      = (state_r == ST_IF) & bp_en & (pc == bp_addr) & ~bp_skip_r;
    assign timeout_trig_s = TIMEOUT_EN & stall_s & (wait_cnt_r == WAIT_W'(MAX_WAIT));
    assign commit_s       = (state_r != ST_HALT) & ~stall_s & ~bp_trig_s & ~timeout_trig_s;
    // A halt_req arriving together with the WB commit also stops here.
    assign wb_halt_s      = halt_pending_r | halt_req | step_mode_r | ~run;

    // Phase reached when the current phase commits.
    always_comb begin
        adv_s = ST_HALT;
        case (state_r)
            ST_IF:   adv_s = ST_DE;
            ST_DE:   adv_s = ST_EX;
            ST_EX:   adv_s = ST_WB;
            ST_WB:   adv_s = wb_halt_s ? ST_HALT : ST_IF;
            default: adv_s = ST_HALT;
        endcase
    end

    // Next-state and control-flag update.
    always_comb begin
        state_s        = state_r;
        wait_cnt_s     = wait_cnt_r;
        halt_pending_s = halt_pending_r;
        step_mode_s    = step_mode_r;
        bp_skip_s      = bp_skip_r;
        bp_hit_s       = bp_hit_r;
        mem_timeout_s  = mem_timeout_r;
        instret_s      = instret_r;
        if (state_r == ST_HALT) begin
            // halt_req is meaningless while halted.
            halt_pending_s = 1'b0;
            wait_cnt_s     = {WAIT_W{1'b0}};
            if (run | step) begin
                // run wins over step; resuming arms the breakpoint skip so
                // the instruction we stopped on can execute once.
                state_s       = ST_IF;
                step_mode_s   = ~run;
                bp_skip_s     = 1'b1;
                bp_hit_s      = 1'b0;
                mem_timeout_s = 1'b0;
            end else begin
                state_s = ST_HALT;
            end
        end else if (bp_trig_s | timeout_trig_s) begin
            // Abort without commit; a timed-out instruction never retires.
            state_s        = ST_HALT;
            halt_pending_s = 1'b0;
            wait_cnt_s     = {WAIT_W{1'b0}};
            bp_hit_s       = bp_hit_r | bp_trig_s;
            mem_timeout_s  = mem_timeout_r | timeout_trig_s;
        end else if (stall_s) begin
            wait_cnt_s     = wait_cnt_r + WAIT_W'(1);
            halt_pending_s = halt_pending_r | halt_req;
        end else begin
            state_s    = adv_s;
            wait_cnt_s = {WAIT_W{1'b0}};
            if (state_r == ST_IF) begin
                bp_skip_s = 1'b0;
            end else begin
                bp_skip_s = bp_skip_r;
            end
            if (state_r == ST_WB) begin
                instret_s = instret_r + CNT_W'(1);
            end else begin
                instret_s = instret_r;
            end
            if (adv_s == ST_HALT) begin
                halt_pending_s = 1'b0;
            end else begin
                halt_pending_s = halt_pending_r | halt_req;
            end
        end
    end

    // State, flags, counters and registered outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r        <= ST_HALT;
            wait_cnt_r     <= {WAIT_W{1'b0}};
            halt_pending_r <= 1'b0;
            step_mode_r    <= 1'b0;
            bp_skip_r      <= 1'b0;
            bp_hit_r       <= 1'b0;
            mem_timeout_r  <= 1'b0;
            instret_r      <= {CNT_W{1'b0}};
            cstate_r       <= PH_HALT;
            running_r      <= 1'b0;
        end else begin
            state_r        <= state_s;
            wait_cnt_r     <= wait_cnt_s;
            halt_pending_r <= halt_pending_s;
            step_mode_r    <= step_mode_s;
            bp_skip_r      <= bp_skip_s;
            bp_hit_r       <= bp_hit_s;
            mem_timeout_r  <= mem_timeout_s;
            instret_r      <= instret_s;
            cstate_r       <= phase_of(state_s);
            running_r      <= (state_s != ST_HALT);
        end
    end

    assign cstate      = cstate_r;
    assign commit      = commit_s;
    assign running     = running_r;
    assign bp_hit      = bp_hit_r;
    assign mem_timeout = mem_timeout_r;
    assign instret     = instret_r;

endmodule

// File: tb/tb_phase_sequencer.sv
// Bench for phase_sequencer: directed scenarios with literal expectations,
// then randomized traffic, all compared every cycle against a phase-index
// reference model (phase 0 = halted, 1..4 = IF..WB).
module tb_phase_sequencer;

    localparam int MAXW = 4;
    localparam int CW   = 4;

    logic          clock = 1'b0;
    logic          reset;
    logic          run, step, halt_req, bp_en, mem_req, mem_ready;
    logic [31:0]   bp_addr, pc;
    logic [3:0]    cstate;
    logic          commit, running, bp_hit, mem_timeout;
    logic [CW-1:0] instret;

    int checks   = 0;
    int failures = 0;

    // reference model state
    int m_ph, m_wait, m_inst;
    bit m_step, m_skip, m_hpend, m_bphit, m_to;

    phase_sequencer #(.MAX_WAIT(MAXW), .CNT_W(CW)) dut (
        .clock(clock), .reset(reset), .run(run), .step(step),
        .halt_req(halt_req), .bp_en(bp_en), .bp_addr(bp_addr), .pc(pc),
        .mem_req(mem_req), .mem_ready(mem_ready), .cstate(cstate),
        .commit(commit), .running(running), .bp_hit(bp_hit),
        .mem_timeout(mem_timeout), .instret(instret)
    );

    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ph = 0; m_wait = 0; m_inst = 0;
        m_step = 0; m_skip = 0; m_hpend = 0; m_bphit = 0; m_to = 0;
    endtask

    function automatic bit m_stall();
        return mem_req && !mem_ready;
    endfunction

    function automatic bit m_bp();
        return (m_ph == 1) && bp_en && (pc == bp_addr) && !m_skip;
    endfunction

    function automatic bit m_tmo();
        return m_stall() && (m_wait == MAXW);
    endfunction

    function automatic bit m_commit();
        return (m_ph != 0) && !m_stall() && !m_bp() && !m_tmo();
    endfunction

    // advance the model by one clock using the current inputs
    task automatic model_step();
        bit bp, to;
        bp = m_bp();
        to = m_tmo();
        if (m_ph == 0) begin
            if (run || step) begin
                m_ph = 1; m_step = !run; m_skip = 1; m_bphit = 0; m_to = 0;
            end
            m_hpend = 0; m_wait = 0;
        end else if (bp || to) begin
            m_bphit = m_bphit | bp; m_to = m_to | to;
            m_ph = 0; m_hpend = 0; m_wait = 0;
        end else if (m_stall()) begin
            m_wait++;
            m_hpend = m_hpend | halt_req;
        end else begin
            m_wait = 0;
            if (m_ph == 1) m_skip = 0;
            if (m_ph == 4) begin
                m_inst = (m_inst + 1) % (1 << CW);
                if (m_hpend || halt_req || m_step || !run) begin
                    m_ph = 0; m_hpend = 0;
                end else begin
                    m_ph = 1; m_hpend = 0;
                end
            end else begin
                m_ph++;
                m_hpend = m_hpend | halt_req;
            end
        end
    endtask

    // called at a negedge with inputs set: compare, clock, advance model
    task automatic tick();
        logic [3:0] ecs;
        #1;
        ecs = (m_ph == 0) ? 4'b0000 : (4'b0001 << (m_ph - 1));
        chk("cstate", {28'd0, cstate}, {28'd0, ecs});
        chk("commit", {31'd0, commit}, {31'd0, m_commit()});
        chk("running", {31'd0, running}, {31'd0, (m_ph != 0)});
        chk("bp_hit", {31'd0, bp_hit}, {31'd0, m_bphit});
        chk("mem_timeout", {31'd0, mem_timeout}, {31'd0, m_to});
        chk("instret", {28'd0, instret}, m_inst);
        @(posedge clock);
        model_step();
        @(negedge clock);
    endtask

    task automatic run_to_halt(input string nm, input int exp_n);
        int n = 0;
        while (cstate != 4'b0000 && n < 20) begin
            tick();
            n++;
        end
        chk(nm, n, exp_n);
    endtask

    logic [3:0] tbl [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    logic [31:0] pcs [5] = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10};

    initial begin
        bit stuck;
        reset = 1'b0; run = 1'b0; step = 1'b0; halt_req = 1'b0; bp_en = 1'b0;
        bp_addr = 32'h0; pc = 32'h0; mem_req = 1'b0; mem_ready = 1'b1;
        model_reset();
        repeat (2) @(negedge clock);
        chk("rst_cstate", {28'd0, cstate}, 32'h0);
        chk("rst_running", {31'd0, running}, 32'h0);
        chk("rst_instret", {28'd0, instret}, 32'h0);
        reset = 1'b1;

        // zero-wait run: 4 cycles per instruction
        run = 1'b1; mem_req = 1'b1; mem_ready = 1'b1;
        tick();
        for (int i = 0; i < 12; i++) begin
            chk("t1_phase", {28'd0, cstate}, {28'd0, tbl[i % 4]});
            chk("t1_commit", {31'd0, commit}, 32'h1);
            tick();
        end
        chk("t1_instret", {28'd0, instret}, 32'd3);
        run = 1'b0;
        repeat (4) tick();
        chk("t1_halt", {28'd0, cstate}, 32'h0);
        chk("t1_instret4", {28'd0, instret}, 32'd4);

        // three wait states in IF: 7-cycle instruction
        run = 1'b1; mem_req = 1'b1; mem_ready = 1'b0;
        tick();
        run = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("t2_hold", {28'd0, cstate}, 32'h1);
            chk("t2_nocommit", {31'd0, commit}, 32'h0);
            tick();
        end
        mem_ready = 1'b1;
        begin
            int n = 3;
            while (cstate != 4'b0000 && n < 20) begin
                tick();
                n++;
            end
            chk("t2_cycles", n, 32'd7);
        end
        chk("t2_instret", {28'd0, instret}, 32'd5);

        // single step twice
        mem_req = 1'b0;
        for (int k = 0; k < 2; k++) begin
            step = 1'b1;
            tick();
            step = 1'b0;
            run_to_halt("t3_step_len", 4);
            chk("t3_running", {31'd0, running}, 32'h0);
        end
        chk("t3_instret", {28'd0, instret}, 32'd7);

        // breakpoint at 0x10
        bp_en = 1'b1; bp_addr = 32'h10; pc = 32'hC; run = 1'b1;
        tick();
        tick();
        pc = 32'h10;
        repeat (3) tick();
        chk("t4_bp_nocommit", {31'd0, commit}, 32'h0);
        tick();
        chk("t4_bp_halt", {28'd0, cstate}, 32'h0);
        chk("t4_bp_hit", {31'd0, bp_hit}, 32'h1);
        chk("t4_instret", {28'd0, instret}, 32'd8);
        run = 1'b0; step = 1'b1;
        tick();
        step = 1'b0;
        chk("t4_bp_clear", {31'd0, bp_hit}, 32'h0);
        chk("t4_if_commit", {31'd0, commit}, 32'h1);
        run_to_halt("t4_step_len", 4);
        chk("t4_instret2", {28'd0, instret}, 32'd9);
        bp_en = 1'b0; pc = 32'h0;

        // halt_req in EX, then coincident with WB
        run = 1'b1;
        repeat (3) tick();
        halt_req = 1'b1;
        tick();
        halt_req = 1'b0;
        chk("t5_wb", {28'd0, cstate}, 32'h8);
        tick();
        chk("t5_halt", {28'd0, cstate}, 32'h0);
        chk("t5_instret", {28'd0, instret}, 32'd10);
        repeat (4) tick();
        halt_req = 1'b1;
        tick();
        halt_req = 1'b0;
        chk("t5_halt_wb", {28'd0, cstate}, 32'h0);
        chk("t5_instret2", {28'd0, instret}, 32'd11);

        // memory timeout in WB
        repeat (4) tick();
        mem_req = 1'b1; mem_ready = 1'b0;
        repeat (4) tick();
        chk("t6_still_wb", {28'd0, cstate}, 32'h8);
        tick();
        chk("t6_halt", {28'd0, cstate}, 32'h0);
        chk("t6_timeout", {31'd0, mem_timeout}, 32'h1);
        chk("t6_instret", {28'd0, instret}, 32'd11);
        mem_req = 1'b0; mem_ready = 1'b1;
        tick();
        chk("t6_clear", {31'd0, mem_timeout}, 32'h0);
        chk("t6_running", {31'd0, running}, 32'h1);
        run = 1'b0;
        run_to_halt("t6_finish", 4);

        // randomized traffic with one asynchronous reset in the middle
        stuck = 1'b0;
        bp_addr = 32'h10;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 29) == 0) run = ~run;
            step     = ($urandom_range(0, 7) == 0);
            halt_req = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 99) == 0) bp_en = ~bp_en;
            pc       = pcs[$urandom_range(0, 4)];
            if (stuck) stuck = ($urandom_range(0, 7) != 0);
            else       stuck = ($urandom_range(0, 49) == 0);
            mem_req   = $urandom_range(0, 1);
            mem_ready = stuck ? 1'b0 : ($urandom_range(0, 3) != 0);
            if (c == 1500) begin
                #3 reset = 1'b0;
                #1;
                model_reset();
                chk("arst_cstate", {28'd0, cstate}, 32'h0);
                chk("arst_commit", {31'd0, commit}, 32'h0);
                chk("arst_instret", {28'd0, instret}, 32'h0);
                @(negedge clock);
                reset = 1'b1;
            end
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
